// File: rtl/mux_accumulator_64.sv
// mux_accumulator_64: one output dimension of the hyperdimensional encoder.
// Each feature byte is added or subtracted according to its projection bit,
// the signed sum is reduced through a binary adder tree, added to the
// supplied previous partial result, and the low OUT_WIDTH bits are
// registered. Single-cycle latency, one result per cycle.

// Per-lane sign selection: zero-extend the feature, negate when proj is 0.
module mux_acc_term #(
  parameter int FTWIDTH   = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic [FTWIDTH-1:0]   feature,
  input  logic                 proj,
  output logic [ACC_WIDTH-1:0] term
);

  logic [ACC_WIDTH-1:0] mag;

  assign mag  = ACC_WIDTH'(feature);
  assign term = proj ? mag : (~mag + ACC_WIDTH'(1));

endmodule

module mux_accumulator_64 #(
  parameter int N_FEAT    = 64,
  parameter int FTWIDTH   = 8,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_FEAT-1:0][FTWIDTH-1:0]  features,
  input  logic [N_FEAT-1:0]               projections,
  input  logic [ACC_WIDTH-1:0]            prev_result,
  output logic [OUT_WIDTH-1:0]            out
);

  // Headroom: magnitude bits for the worst-case sum, plus sign, plus one
  // spare so the tree can never overflow.
  localparam int MAX_MAG = N_FEAT * ((2 ** FTWIDTH) - 1);
  localparam int MIN_ACC = $clog2(MAX_MAG) + 2;

  // Tree is padded to a power of two; unused leaves are tied to zero.
  localparam int LV = (N_FEAT > 1) ? $clog2(N_FEAT) : 0;
  localparam int NP = 1 << LV;

  if (ACC_WIDTH < MIN_ACC) begin : g_acc_too_narrow
    $error("mux_accumulator_64: ACC_WIDTH too narrow for N_FEAT/FTWIDTH");
  end
  if (OUT_WIDTH > ACC_WIDTH) begin : g_out_too_wide
    $error("mux_accumulator_64: OUT_WIDTH must not exceed ACC_WIDTH");
  end

  logic [N_FEAT-1:0][ACC_WIDTH-1:0] terms;
  logic [ACC_WIDTH-1:0]             tree_sum;

  // One sign-select lane per feature.
  for (genvar j = 0; j < N_FEAT; j++) begin : g_lane
    mux_acc_term #(
      .FTWIDTH   (FTWIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_term (
      .feature (features[j]),
      .proj    (projections[j]),
      .term    (terms[j])
    );
  end

  // Binary adder tree: level 0 holds the leaves, level LV holds the root.
  // Each level lives in its own generate scope so no signal feeds itself.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic [ACC_WIDTH-1:0] s [NP >> l];
    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < NP; k++) begin : g_k
        if (k < N_FEAT) begin : g_real
          assign s[k] = terms[k];
        end else begin : g_pad
          assign s[k] = '0;
        end
      end
    end else begin : g_node
      for (genvar k = 0; k < (NP >> l); k++) begin : g_k
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end

  assign tree_sum = g_lvl[LV].s[0];

  // Register the low bits of prev_result + sum; upper bits wrap away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out <= '0;
    else        out <= OUT_WIDTH'(prev_result + tree_sum);
  end

endmodule

// File: tb/tb_mux_accumulator_64.sv
// Directed bench for mux_accumulator_64: reset behaviour, add/subtract
// extremes, wrap, cancellation, back-to-back pipelining and mid-op reset.
module tb_mux_accumulator_64;

  logic                 clk;
  logic                 reset;
  logic [63:0][7:0]     features;
  logic [63:0]          projections;
  logic [15:0]          prev_result;
  logic [7:0]           out;

  int n_vec  = 0;
  int n_miss = 0;

  mux_accumulator_64 dut (
    .clk         (clk),
    .reset       (reset),
    .features    (features),
    .projections (projections),
    .prev_result (prev_result),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] f, input logic [63:0] p, input logic [15:0] pr);
    for (int j = 0; j < 64; j++) features[j] = f;
    projections = p;
    prev_result = pr;
  endtask

  // Independent reference: integer signed sum, then keep the low byte.
  function automatic logic [7:0] ref_t(input logic [63:0][7:0] f,
                                       input logic [63:0] p,
                                       input logic [15:0] pr);
    int s;
    s = int'($signed(pr));
    for (int j = 0; j < 64; j++) s += p[j] ? int'(f[j]) : -int'(f[j]);
    return 8'(s);
  endfunction

  task automatic randomize_inputs();
    for (int j = 0; j < 64; j++) features[j] = 8'($urandom);
    projections = {$urandom, $urandom};
    prev_result = 16'($urandom);
  endtask

  // Apply current inputs, step one edge, check the registered result.
  task automatic step_chk(input string tag, input logic [7:0] exp);
    @(posedge clk); #1;
    chk(tag, out, exp);
  endtask

  logic [7:0] exp_q;
  logic [7:0] hold_q;

  initial begin
    reset = 1'b0;
    randomize_inputs();
    #1;
    chk("reset_async_t0", out, 8'h00);
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      @(posedge clk); #1;
      chk("reset_held_edge", out, 8'h00);
    end

    // Release between edges; first edge with reset high loads.
    #2;
    reset = 1'b1;
    set_all(8'd1, '1, 16'd0);
    step_chk("all_add", 8'h40);

    set_all(8'd1, '0, 16'd0);
    step_chk("all_sub", 8'hC0);

    set_all(8'd1, '1, 16'd100);
    step_chk("add_prev100", 8'hA4);

    set_all(8'd255, '1, 16'd0);
    step_chk("all_255_wrap", 8'hC0);

    set_all(8'd255, '0, 16'd0);
    step_chk("all_255_sub", 8'h40);

    set_all(8'd7, 64'h5555_5555_5555_5555, 16'h1234);
    step_chk("cancel", 8'h34);

    set_all(8'd1, '1, 16'hFFFF);
    step_chk("prev_neg1", 8'h3F);

    // features[j] = j, all add: 2016 = 0x7E0.
    for (int j = 0; j < 64; j++) features[j] = 8'(j);
    projections = '1;
    prev_result = 16'h0000;
    step_chk("ramp_add", 8'hE0);

    // Inputs changing between edges must not reach out.
    hold_q = out;
    set_all(8'd3, '1, 16'h0011);
    #2;
    chk("no_comb_path", out, hold_q);
    step_chk("after_hold", 8'hD1);

    // Back-to-back: new inputs every cycle.
    for (int i = 0; i < 12; i++) begin
      randomize_inputs();
      exp_q = ref_t(features, projections, prev_result);
      step_chk("pipe", exp_q);
    end

    // Mid-op reset between edges clears at once.
    randomize_inputs();
    #2;
    reset = 1'b0;
    #1;
    chk("midop_reset_async", out, 8'h00);
    @(posedge clk); #1;
    chk("midop_reset_edge", out, 8'h00);
    #2;
    reset = 1'b1;
    randomize_inputs();
    exp_q = ref_t(features, projections, prev_result);
    step_chk("resume", exp_q);
    randomize_inputs();
    exp_q = ref_t(features, projections, prev_result);
    step_chk("resume2", exp_q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
